apb_rd_resp_buffer: RTL and testbench

Downstream stage of the APB read/write system. Consumes the system's read-response strobe (rd_valid/rd_data), which has no backpressure, and buffers each accepted response in a circular FIFO. Each response is tagged with a sequence number and drained through a valid/ready stream. Tracks drops, overflow and non-monotonic read data; the system's read-then-increment traffic must never return decreasing data.

---
 rtl/apb_resp_pkg.sv | 28 ++
 rtl/apb_rd_resp_buffer_if.sv | 48 ++++
 rtl/resp_fifo_core.sv | 63 ++++++
 rtl/apb_rd_resp_buffer.sv | 183 ++++++++++++++++++
 tb/tb_apb_rd_resp_buffer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/apb_resp_pkg.sv
// Shared definitions for the APB read-response buffer.
//
// Contents:
//   RESP_TS_W    - width of the per-entry capture timestamp
//   DROP_CNT_W   - width of the saturating dropped-beat counter
//   RESP_DATA_W  - default response data width
//   RESP_SEQ_W   - default sequence tag width
//   resp_entry_t - FIFO entry layout for the default widths
//
// Build option: RESP_TIMESTAMP_EN adds a timestamp field to each entry.
package apb_resp_pkg;

    localparam int unsigned RESP_TS_W   = 16;
    localparam int unsigned DROP_CNT_W  = 16;
    localparam int unsigned RESP_DATA_W = 32;
    localparam int unsigned RESP_SEQ_W  = 8;

    // Field order is data, seq[, ts], MSB first; the top rebuilds the same layout
    // for non-default DATA_W/SEQ_W.
    typedef struct packed {
        logic [RESP_DATA_W-1:0] data;
        logic [RESP_SEQ_W-1:0]  seq;
`ifdef RESP_TIMESTAMP_EN
        logic [RESP_TS_W-1:0]   ts;
`endif
    } resp_entry_t;

endpackage

// File: rtl/apb_rd_resp_buffer_if.sv
// Response-side bus of apb_rd_resp_buffer: the incoming read-response strobe
// (no backpressure) and the outgoing valid/ready stream of buffered entries.
//
// Signals:
//   rd_valid_i, rd_data_i      - read response strobe and data from the APB system
//   out_valid_o, out_ready_i   - head-entry handshake
//   out_data_o, out_seq_o      - head entry data and sequence tag (0 when empty)
//   out_ts_o                   - head entry timestamp (RESP_TIMESTAMP_EN only)
//
// Modports: slave for the buffer, master for whatever drives/consumes it.
// Build option: RESP_TIMESTAMP_EN.
interface apb_rd_resp_buffer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SEQ_W  = 8
);
    import apb_resp_pkg::*;

    logic              rd_valid_i;
    logic [DATA_W-1:0] rd_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_data_o;
    logic [SEQ_W-1:0]  out_seq_o;
`ifdef RESP_TIMESTAMP_EN
    logic [RESP_TS_W-1:0] out_ts_o;

    modport slave (
        input  rd_valid_i, rd_data_i, out_ready_i,
        output out_valid_o, out_data_o, out_seq_o, out_ts_o
    );

    modport master (
        output rd_valid_i, rd_data_i, out_ready_i,
        input  out_valid_o, out_data_o, out_seq_o, out_ts_o
    );
`else
    modport slave (
        input  rd_valid_i, rd_data_i, out_ready_i,
        output out_valid_o, out_data_o, out_seq_o
    );

    modport master (
        output rd_valid_i, rd_data_i, out_ready_i,
        input  out_valid_o, out_data_o, out_seq_o
    );
`endif

endinterface

// File: rtl/resp_fifo_core.sv
// Circular FIFO storage for apb_rd_resp_buffer.
//
// Ports:
//   clk, reset  - clock; asynchronous active-high reset (empties the FIFO)
//   push_i      - write wdata_i at the write pointer (caller guarantees room)
//   pop_i       - advance the read pointer (caller guarantees not empty)
//   wdata_i     - entry to store
//   rdata_o     - entry at the read pointer, combinational
//   full_o      - DEPTH entries held
//   empty_o     - no entries held
//   count_o     - occupancy, wr_ptr - rd_ptr
//
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter. DEPTH must be a power of two, >= 2.
module resp_fifo_core #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 40
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;

    // Storage is not reset: stale contents are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign rdata_o = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/apb_rd_resp_buffer.sv
// Read-response buffer at the tail of the APB read/write system.
//
// Captures the backpressure-free read-response strobe, optionally suppressing a
// beat identical to the previous cycle's beat, tags every capture with a
// sequence number and queues it for a valid/ready consumer. Beats arriving while
// the FIFO is full (and not popping) are dropped but still consume a sequence
// number, so gaps in the tags expose losses.
//
// Ports:
//   clk, reset   - clock; asynchronous active-high reset
//   bus          - apb_rd_resp_buffer_if.slave: rd_valid_i/rd_data_i in,
//                  out_valid_o/out_ready_i/out_data_o/out_seq_o[/out_ts_o] out
//   clear_i      - synchronous clear of sticky flags, drop count, monotonic history
//   count_o      - FIFO occupancy
//   overflow_o   - sticky: a beat was dropped while full
//   drop_cnt_o   - dropped beats, saturating at all-ones
//   mono_err_o   - sticky: a captured beat was below the previous capture
//
// Build option: RESP_TIMESTAMP_EN stores a free-running 16-bit cycle counter
// with each entry and presents it on bus.out_ts_o.
module apb_rd_resp_buffer
    import apb_resp_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SEQ_W  = 8,
    parameter int unsigned DEDUP  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    apb_rd_resp_buffer_if.slave       bus,
    input  logic                      clear_i,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      overflow_o,
    output logic [DROP_CNT_W-1:0]     drop_cnt_o,
    output logic                      mono_err_o
);

    typedef struct packed {
        logic [DATA_W-1:0]    data;
        logic [SEQ_W-1:0]     seq;
`ifdef RESP_TIMESTAMP_EN
        logic [RESP_TS_W-1:0] ts;
`endif
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

    // Previous-cycle beat, for dedup.
    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    logic [SEQ_W-1:0]      seq_q;
    logic [DROP_CNT_W-1:0] drop_cnt_q;
    logic                  overflow_q;
    logic                  mono_err_q;
    logic                  has_last_q;
    logic [DATA_W-1:0]     last_q;

`ifdef RESP_TIMESTAMP_EN
    logic [RESP_TS_W-1:0]  ts_q;
`endif

    logic               dup;
    logic               cap;
    logic               push;
    logic               pop;
    logic               drop;
    logic               mono_viol;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_rdata;
    entry_t             wr_entry;
    entry_t             rd_entry;

    assign dup       = (DEDUP != 0) && valid_q && (bus.rd_data_i == data_q);
    assign cap       = bus.rd_valid_i && !dup;
    assign pop       = !fifo_empty && bus.out_ready_i;
    // A full FIFO still accepts a beat when the head leaves in the same cycle.
    assign push      = cap && (!fifo_full || pop);
    assign drop      = cap && fifo_full && !pop;
    assign mono_viol = cap && has_last_q && (bus.rd_data_i < last_q);

    always_comb begin
        wr_entry      = '0;
        wr_entry.data = bus.rd_data_i;
        wr_entry.seq  = seq_q;
`ifdef RESP_TIMESTAMP_EN
        wr_entry.ts   = ts_q;
`endif
    end

    resp_fifo_core #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_entry),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count_o)
    );

    assign rd_entry = fifo_rdata;

    // Head is zero-gated so an empty FIFO never shows stale storage.
    assign bus.out_valid_o = !fifo_empty;
    assign bus.out_data_o  = fifo_empty ? '0 : rd_entry.data;
    assign bus.out_seq_o   = fifo_empty ? '0 : rd_entry.seq;
`ifdef RESP_TIMESTAMP_EN
    assign bus.out_ts_o    = fifo_empty ? '0 : rd_entry.ts;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            seq_q   <= '0;
        end else begin
            valid_q <= bus.rd_valid_i;
            data_q  <= bus.rd_data_i;
            // Dropped beats also consume a tag.
            if (cap) begin
                seq_q <= seq_q + SEQ_W'(1);
            end
        end
    end

    // Statistics: an event in the same cycle as clear_i takes precedence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            mono_err_q <= 1'b0;
            has_last_q <= 1'b0;
            last_q     <= '0;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
                if (clear_i) begin
                    drop_cnt_q <= DROP_CNT_W'(1);
                end else if (drop_cnt_q != '1) begin
                    drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
                end
            end else if (clear_i) begin
                overflow_q <= 1'b0;
                drop_cnt_q <= '0;
            end

            if (mono_viol) begin
                mono_err_q <= 1'b1;
            end else if (clear_i) begin
                mono_err_q <= 1'b0;
            end

            if (cap) begin
                last_q     <= bus.rd_data_i;
                has_last_q <= 1'b1;
            end else if (clear_i) begin
                has_last_q <= 1'b0;
            end
        end
    end

`ifdef RESP_TIMESTAMP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + RESP_TS_W'(1);
        end
    end
`endif

    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_cnt_q;
    assign mono_err_o = mono_err_q;

endmodule

// File: tb/tb_apb_rd_resp_buffer.sv
module tb_apb_rd_resp_buffer;
    import apb_resp_pkg::*;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEQ_W  = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear;
    logic [2:0]  count;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic        mono_err;

    int n_cmp  = 0;
    int n_fail = 0;

    apb_rd_resp_buffer_if #(.DATA_W(DATA_W), .SEQ_W(SEQ_W)) bus ();

    apb_rd_resp_buffer #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .SEQ_W  (SEQ_W),
        .DEDUP  (1)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .clear_i    (clear),
        .count_o    (count),
        .overflow_o (overflow),
        .drop_cnt_o (drop_cnt),
        .mono_err_o (mono_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [SEQ_W-1:0]  seq;
    } exp_t;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        rdy;
        logic        clr;
        logic        e_ovf;
        logic [15:0] e_drop;
        logic        e_mono;
    } vec_t;

    // Scoreboard and reference state for dedup/sequence/capacity.
    exp_t              sbq[$];
    logic              m_vq;
    logic [DATA_W-1:0] m_dq;
    logic [SEQ_W-1:0]  m_seq;
    vec_t              vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [31:0] d, input logic rdy,
                                input logic clr, input logic e_ovf, input logic [15:0] e_drop,
                                input logic e_mono);
        vec_t r;
        r.v = v; r.d = d; r.rdy = rdy; r.clr = clr;
        r.e_ovf = e_ovf; r.e_drop = e_drop; r.e_mono = e_mono;
        return r;
    endfunction

    function automatic void model_reset();
        sbq.delete();
        m_vq  = 1'b0;
        m_dq  = '0;
        m_seq = '0;
    endfunction

    // One cycle: drive at posedge+1, check the head mid-cycle, check count after the edge.
    task automatic step(input logic v, input logic [31:0] d, input logic rdy, input logic clr);
        exp_t e;
        bit   dup, cap, full, pop;
        bus.rd_valid_i  = v;
        bus.rd_data_i   = d;
        bus.out_ready_i = rdy;
        clear           = clr;
        #4;
        if (sbq.size() > 0) begin
            check("head_valid", 64'(bus.out_valid_o), 64'd1);
            check("head_data", 64'(bus.out_data_o), 64'(sbq[0].data));
            check("head_seq", 64'(bus.out_seq_o), 64'(sbq[0].seq));
        end else begin
            check("empty_valid", 64'(bus.out_valid_o), 64'd0);
            check("empty_data", 64'(bus.out_data_o), 64'd0);
            check("empty_seq", 64'(bus.out_seq_o), 64'd0);
        end
        pop  = rdy && (sbq.size() > 0);
        full = (sbq.size() == DEPTH);
        dup  = m_vq && v && (d == m_dq);
        cap  = v && !dup;
        if (pop) void'(sbq.pop_front());
        if (cap) begin
            if (!full || pop) begin
                e.data = d;
                e.seq  = m_seq;
                sbq.push_back(e);
            end
            m_seq = m_seq + 1'b1;
        end
        m_vq = v;
        m_dq = d;
        @(posedge clk);
        #1;
        check("count", 64'(count), 64'(sbq.size()));
    endtask

    initial begin
        bus.rd_valid_i  = 1'b0;
        bus.rd_data_i   = '0;
        bus.out_ready_i = 1'b0;
        clear           = 1'b0;
        model_reset();

        // Single beat, then pop.
        vecs.push_back(mk(1, 32'h5, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0, 0, 0, 0, 0, 0));
        // Dedup: held value gives one entry; a gap re-arms it.
        vecs.push_back(mk(1, 32'h7, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h7, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h7, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h7, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0, 1, 0, 0, 0, 0));
        // Overflow: 6 beats into 4 entries.
        vecs.push_back(mk(1, 32'h1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h3, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h4, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h5, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 32'h6, 0, 0, 1, 2, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 32'h0, 1, 0, 1, 2, 0));
        // Full with simultaneous pop and push, then drop coinciding with clear.
        vecs.push_back(mk(1, 32'h7, 0, 0, 1, 2, 0));
        vecs.push_back(mk(1, 32'h8, 0, 0, 1, 2, 0));
        vecs.push_back(mk(1, 32'h9, 0, 0, 1, 2, 0));
        vecs.push_back(mk(1, 32'hA, 0, 0, 1, 2, 0));
        vecs.push_back(mk(1, 32'hB, 1, 0, 1, 2, 0));
        vecs.push_back(mk(1, 32'hC, 0, 1, 1, 1, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 32'h0, 1, 0, 1, 1, 0));
        // Monotonic check and history clear.
        vecs.push_back(mk(1, 32'h10, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 32'h0F, 0, 0, 1, 1, 1));
        vecs.push_back(mk(0, 32'h0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 32'h0E, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h0D, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 32'h0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 32'h0, 0, 1, 0, 0, 0));

        #2;
        check("rst_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst_data", 64'(bus.out_data_o), 64'd0);
        check("rst_seq", 64'(bus.out_seq_o), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        check("rst_mono", 64'(mono_err), 64'd0);
        #10;
        reset = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].d, vecs[i].rdy, vecs[i].clr);
            check($sformatf("ovf[%0d]", i), 64'(overflow), 64'(vecs[i].e_ovf));
            check($sformatf("drop[%0d]", i), 64'(drop_cnt), 64'(vecs[i].e_drop));
            check($sformatf("mono[%0d]", i), 64'(mono_err), 64'(vecs[i].e_mono));
        end

        // Reset mid-operation with three entries held.
        step(1, 32'h20, 0, 0);
        step(1, 32'h21, 0, 0);
        step(1, 32'h22, 0, 1);
        check("pre_rst_count", 64'(count), 64'd3);
        bus.rd_valid_i = 1'b0;
        bus.rd_data_i  = '0;
        clear          = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check("midrst_valid", 64'(bus.out_valid_o), 64'd0);
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_data", 64'(bus.out_data_o), 64'd0);
        model_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        step(1, 32'h30, 0, 0);
`ifdef RESP_TIMESTAMP_EN
        check("ts_after_rst", 64'(bus.out_ts_o), 64'd1);
`endif
        step(0, 32'h0, 1, 0);
        check("post_rst_ovf", 64'(overflow), 64'd0);
        check("post_rst_drop", 64'(drop_cnt), 64'd0);
        step(0, 32'h0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
